// File: rtl/even_issue_scheduler.sv
// even_issue_scheduler
//   Issue control for the even execution pipe (FP, FX2, Byte, FX1 share one
//   forwarding/writeback chain). Each cycle it decides whether the presented
//   instruction may issue. It stalls on RAW hazards against producers that
//   have not reached their result stage, and on writeback-slot collisions in
//   the shared chain. A branch flush kills young in-flight work. The block
//   also counts stall cycles.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   req_valid             instruction presented (held by requester until ready)
//   req_unit              0 FP, 1 FX2, 2 Byte, 3 FX1
//   req_fp_int            FP integer op (longer latency), FP unit only
//   req_reg_write/rt_addr destination write enable / register
//   req_r{a,b,c}_addr     source registers, gated by req_use_r{a,b,c}
//   branch_flush          taken branch: block issue, kill young entries
//   req_ready             combinational issue decision
//   issue_fire/issue_unit registered issue pulse and unit (RF-stage aligned)
//   stall_raw/stall_wb    combinational stall causes
//   inflight_cnt          valid scoreboard entries
//   stall_cycles          saturating count of valid-but-not-ready cycles

// Hazard compare for one scoreboard slot. AGE is the slot's age in cycles
// since issue (slot k holds age k+1).
module even_issue_slot_cmp #(
  parameter int AGE = 1
) (
  input  logic            vld,
  input  logic            wr,
  input  logic [6:0]      rt,
  input  logic [2:0]      lat,
  input  logic [2:0][6:0] src,
  input  logic [2:0]      use_src,
  input  logic [2:0]      req_lat,
  output logic            raw_hit,
  output logic            wb_hit
);
  localparam logic [3:0] AGE_W = 4'(AGE);

  logic live;
  logic src_match;

  assign live = vld && wr;

  always_comb begin
    src_match = 1'b0;
    for (int i = 0; i < 3; i++)
      if (use_src[i] && (src[i] == rt)) src_match = 1'b1;
  end

  // Result becomes forwardable exactly when age reaches lat.
  assign raw_hit = live && src_match && (AGE_W < {1'b0, lat});
  // Both results land in the same chain slot when lat - age == new latency.
  // This is written as an add so that it cannot underflow.
  assign wb_hit  = live && ({1'b0, lat} == ({1'b0, req_lat} + AGE_W));
endmodule

module even_issue_scheduler #(
  parameter int LAT_FP   = 6,
  parameter int LAT_FPI  = 7,
  parameter int LAT_FX2  = 4,
  parameter int LAT_B1   = 4,
  parameter int LAT_FX1  = 2,
  parameter int KILL_AGE = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [1:0]  req_unit,
  input  logic        req_fp_int,
  input  logic        req_reg_write,
  input  logic [6:0]  req_rt_addr,
  input  logic [6:0]  req_ra_addr,
  input  logic [6:0]  req_rb_addr,
  input  logic [6:0]  req_rc_addr,
  input  logic        req_use_ra,
  input  logic        req_use_rb,
  input  logic        req_use_rc,
  input  logic        branch_flush,
  output logic        req_ready,
  output logic        issue_fire,
  output logic [1:0]  issue_unit,
  output logic        stall_raw,
  output logic        stall_wb,
  output logic [2:0]  inflight_cnt,
  output logic [31:0] stall_cycles
);
  localparam int STAGES = 6;  // slots 0..STAGES, seven deep

  typedef struct packed {
    logic       wr;
    logic [6:0] rt;
    logic [2:0] lat;
  } sb_ent_t;

  logic [STAGES:0]   vld_pipe;
  sb_ent_t [STAGES:0] ent;
  logic [STAGES:0]   raw_hit, wb_hit;
  logic [2:0][6:0]   src;
  logic [2:0]        use_src;
  logic [2:0]        req_lat;

  assign src     = {req_rc_addr, req_rb_addr, req_ra_addr};
  assign use_src = {req_use_rc, req_use_rb, req_use_ra};

  always_comb begin
    req_lat = 3'(LAT_FX1);
    case (req_unit)
      2'd0: req_lat = req_fp_int ? 3'(LAT_FPI) : 3'(LAT_FP);
      2'd1: req_lat = 3'(LAT_FX2);
      2'd2: req_lat = 3'(LAT_B1);
      2'd3: req_lat = 3'(LAT_FX1);
      default: req_lat = 3'(LAT_FX1);
    endcase
  end

  for (genvar k = 0; k <= STAGES; k++) begin : g_slot
    even_issue_slot_cmp #(.AGE(k + 1)) u_cmp (
      .vld     (vld_pipe[k]),
      .wr      (ent[k].wr),
      .rt      (ent[k].rt),
      .lat     (ent[k].lat),
      .src     (src),
      .use_src (use_src),
      .req_lat (req_lat),
      .raw_hit (raw_hit[k]),
      .wb_hit  (wb_hit[k])
    );
  end

  // Stall causes are evaluated whether or not req_valid is set.
  assign stall_raw = !reset && (|raw_hit);
  assign stall_wb  = !reset && req_reg_write && (|wb_hit);
  assign req_ready = !reset && req_valid && !stall_raw && !stall_wb && !branch_flush;

  always_comb begin
    inflight_cnt = '0;
    for (int k = 0; k <= STAGES; k++) inflight_cnt = inflight_cnt + 3'(vld_pipe[k]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe     <= '0;
      ent          <= '0;
      issue_fire   <= 1'b0;
      issue_unit   <= '0;
      stall_cycles <= '0;
    end else begin
      // Slot 0 takes the issuing instruction. A flush already blocks issue,
      // so slot 0 is empty on a flush edge without any extra logic.
      vld_pipe[0] <= req_ready;
      ent[0]      <= '{wr: req_reg_write, rt: req_rt_addr, lat: req_lat};
      for (int k = 1; k <= STAGES; k++) begin
        vld_pipe[k] <= vld_pipe[k-1] && !(branch_flush && (k < KILL_AGE));
        ent[k]      <= ent[k-1];
      end
      issue_fire <= req_ready;
      if (req_ready) issue_unit <= req_unit;
      if (req_valid && !req_ready && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;
    end
  end
endmodule

// File: tb/tb_even_issue_scheduler.sv
// Scoreboard bench for even_issue_scheduler: directed vectors push the
// expected issue (unit, cycle) into a queue, and a monitor pops and compares
// on every issue_fire.
module tb_even_issue_scheduler;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_fp_int, req_reg_write, branch_flush;
  logic [1:0]  req_unit;
  logic [6:0]  req_rt_addr, req_ra_addr, req_rb_addr, req_rc_addr;
  logic        req_use_ra, req_use_rb, req_use_rc;
  logic        req_ready, issue_fire, stall_raw, stall_wb;
  logic [1:0]  issue_unit;
  logic [2:0]  inflight_cnt;
  logic [31:0] stall_cycles;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  typedef struct {
    logic [1:0] unit;
    int         cyc;
  } exp_t;
  exp_t q[$];

  even_issue_scheduler dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_unit(req_unit),
    .req_fp_int(req_fp_int), .req_reg_write(req_reg_write),
    .req_rt_addr(req_rt_addr), .req_ra_addr(req_ra_addr),
    .req_rb_addr(req_rb_addr), .req_rc_addr(req_rc_addr),
    .req_use_ra(req_use_ra), .req_use_rb(req_use_rb), .req_use_rc(req_use_rc),
    .branch_flush(branch_flush), .req_ready(req_ready),
    .issue_fire(issue_fire), .issue_unit(issue_unit),
    .stall_raw(stall_raw), .stall_wb(stall_wb),
    .inflight_cnt(inflight_cnt), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every issue pulse must match the oldest expected issue.
  always @(negedge clk) begin
    if (issue_fire === 1'b1) begin
      if (q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_fire: got fire at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("fire_unit", 32'(issue_unit), 32'(e.unit));
        chk("fire_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    branch_flush = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] unit, input logic fpi, input logic wr,
                       input logic [6:0] rt, input logic [6:0] ra, input logic ua,
                       input logic [6:0] rb, input logic ub,
                       input logic [6:0] rc, input logic uc);
    req_valid = 1'b1; req_unit = unit; req_fp_int = fpi; req_reg_write = wr;
    req_rt_addr = rt; req_ra_addr = ra; req_rb_addr = rb; req_rc_addr = rc;
    req_use_ra = ua; req_use_rb = ub; req_use_rc = uc;
  endtask

  // Present an instruction and hold it until it issues. The stall count and
  // the first-cycle stall flags are checked against hand-computed values.
  task automatic send(input logic [1:0] unit, input logic fpi, input logic wr,
                      input logic [6:0] rt, input logic [6:0] ra, input logic ua,
                      input logic [6:0] rb, input logic ub,
                      input logic [6:0] rc, input logic uc,
                      input int exp_stall, input logic exp_raw, input logic exp_wb,
                      input string name);
    int stalls;
    int start;
    branch_flush = 1'b0;
    drive(unit, fpi, wr, rt, ra, ua, rb, ub, rc, uc);
    start = cyc;
    @(negedge clk);
    chk({name, "_raw"}, 32'(stall_raw), 32'(exp_raw));
    chk({name, "_wb"}, 32'(stall_wb), 32'(exp_wb));
    stalls = 0;
    while (req_ready !== 1'b1 && stalls < 20) begin
      stalls++;
      @(negedge clk);
    end
    chk({name, "_stalls"}, 32'(stalls), 32'(exp_stall));
    if (req_ready === 1'b1) q.push_back('{unit: unit, cyc: start + exp_stall + 1});
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    branch_flush = 1'b0;
    drive(2'd3, 1'b0, 1'b0, 7'd0, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0);
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // The request must stay blocked while reset is high.
    req_valid = 1'b1;
    @(negedge clk);
    chk("ready_in_reset", 32'(req_ready), 32'd0);
    step();
    reset = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_inflight", 32'(inflight_cnt), 32'd0);
    chk("rst_fire", 32'(issue_fire), 32'd0);
    chk("rst_unit", 32'(issue_unit), 32'd0);
    chk("rst_stalls", stall_cycles, 32'd0);
    step();

    // Back-to-back independent issue.
    send(2'd3, 0, 1, 7'd5, 7'd1, 1, 7'd2, 0, 7'd0, 0, 0, 0, 0, "b2b_fx1");
    send(2'd1, 0, 1, 7'd6, 7'd1, 1, 7'd2, 1, 7'd0, 0, 0, 0, 0, "b2b_fx2");
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_inflight", 32'(inflight_cnt), 32'd2);
    step();
    idle(8);
    chk("drain_inflight", 32'(inflight_cnt), 32'd0);

    // RAW on FP float: 5 stalls.
    send(2'd0, 0, 1, 7'd10, 7'd0, 0, 7'd0, 0, 7'd0, 0, 0, 0, 0, "fp_prod");
    send(2'd3, 0, 0, 7'd0, 7'd10, 1, 7'd0, 0, 7'd0, 0, 5, 1, 0, "fp_cons");
    idle(8);
    chk("raw_stall_cnt", stall_cycles, 32'd5);

    // WB collision: FX2 writing at t2 behind an FP float issued at t0.
    send(2'd0, 0, 1, 7'd12, 7'd0, 0, 7'd0, 0, 7'd0, 0, 0, 0, 0, "wb_prod");
    idle(1);
    send(2'd1, 0, 1, 7'd20, 7'd0, 0, 7'd0, 0, 7'd0, 0, 1, 0, 1, "wb_coll");
    idle(8);
    send(2'd0, 0, 1, 7'd13, 7'd0, 0, 7'd0, 0, 7'd0, 0, 0, 0, 0, "wb_prod2");
    idle(1);
    send(2'd1, 0, 0, 7'd21, 7'd0, 0, 7'd0, 0, 7'd0, 0, 0, 0, 0, "wb_nowr");
    idle(8);
    chk("wb_stall_cnt", stall_cycles, 32'd6);

    // FP integer latency: 6 stalls, with the consumer reading through rb.
    send(2'd0, 1, 1, 7'd3, 7'd0, 0, 7'd0, 0, 7'd0, 0, 0, 0, 0, "fpi_prod");
    send(2'd3, 0, 0, 7'd0, 7'd0, 0, 7'd3, 1, 7'd0, 0, 6, 1, 0, "fpi_cons");
    idle(8);
    chk("fpi_stall_cnt", stall_cycles, 32'd12);

    // A source that is not used must not stall.
    send(2'd3, 0, 1, 7'd7, 7'd0, 0, 7'd0, 0, 7'd0, 0, 0, 0, 0, "use_prod");
    send(2'd1, 0, 0, 7'd0, 7'd7, 0, 7'd0, 0, 7'd0, 0, 0, 0, 0, "use_off");
    idle(8);
    // Byte unit producer, consumer reading through rc: 3 stalls.
    send(2'd2, 0, 1, 7'd9, 7'd0, 0, 7'd0, 0, 7'd0, 0, 0, 0, 0, "b1_prod");
    send(2'd3, 0, 0, 7'd0, 7'd0, 0, 7'd0, 0, 7'd9, 1, 3, 1, 0, "b1_cons");
    idle(8);
    chk("b1_stall_cnt", stall_cycles, 32'd15);

    // Branch flush kills the age-1 producer; the consumer issues at once.
    send(2'd1, 0, 1, 7'd8, 7'd0, 0, 7'd0, 0, 7'd0, 0, 0, 0, 0, "fl_prod");
    drive(2'd3, 0, 1, 7'd30, 7'd0, 0, 7'd0, 0, 7'd0, 0);
    branch_flush = 1'b1;
    @(negedge clk);
    chk("flush_blocks", 32'(req_ready), 32'd0);
    step();
    send(2'd3, 0, 0, 7'd0, 7'd8, 1, 7'd0, 0, 7'd0, 0, 0, 0, 0, "fl_cons");
    req_valid = 1'b0;
    @(negedge clk);
    chk("fl_inflight", 32'(inflight_cnt), 32'd1);
    chk("fl_stall_cnt", stall_cycles, 32'd16);
    step();
    idle(8);

    // An older entry survives the flush: flush at age 3, consumer at age 4.
    send(2'd0, 0, 1, 7'd15, 7'd0, 0, 7'd0, 0, 7'd0, 0, 0, 0, 0, "old_prod");
    idle(2);
    branch_flush = 1'b1;
    step();
    send(2'd3, 0, 0, 7'd0, 7'd15, 1, 7'd0, 0, 7'd0, 0, 2, 1, 0, "old_cons");
    idle(8);
    chk("old_stall_cnt", stall_cycles, 32'd18);

    // Reset while work is in flight.
    send(2'd0, 0, 1, 7'd40, 7'd0, 0, 7'd0, 0, 7'd0, 0, 0, 0, 0, "rs_a");
    send(2'd1, 0, 1, 7'd41, 7'd0, 0, 7'd0, 0, 7'd0, 0, 0, 0, 0, "rs_b");
    send(2'd3, 0, 1, 7'd42, 7'd0, 0, 7'd0, 0, 7'd0, 0, 0, 0, 0, "rs_c");
    drive(2'd3, 0, 0, 7'd0, 7'd40, 1, 7'd0, 0, 7'd0, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("rs_ready_low", 32'(req_ready), 32'd0);
    chk("rs_raw_forced", 32'(stall_raw), 32'd0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rs_inflight", 32'(inflight_cnt), 32'd0);
    chk("rs_stall_cnt", stall_cycles, 32'd0);
    chk("rs_fire", 32'(issue_fire), 32'd0);
    chk("rs_cons_ready", 32'(req_ready), 32'd1);
    if (req_ready === 1'b1) q.push_back('{unit: 2'd3, cyc: cyc + 1});
    step();
    idle(3);

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
